// File: rtl/tft_timing_gen.sv
`default_nettype none
// ============================================================================
// Module      : tft_timing_gen
// Description : TFT-LCD raster timing generator on the pixel clock. Produces
//               pixel/line counters, active-low Hsync/Vsync, hDE/vDE/DE and
//               line/frame start pulses, all registered and mutually aligned.
//               Optional 8-bar colour test pattern on R/G/B, enabled by
//               defining the macro TFT_TIMING_PATTERN_EN (R/G/B tie to 0
//               otherwise).
// Revision    : 1.0 - initial release
// ============================================================================
module tft_timing_gen #(
  parameter int H_ACTIVE = 480,
  parameter int H_FP     = 2,
  parameter int H_SYNC   = 41,
  parameter int H_BP     = 2,
  parameter int V_ACTIVE = 272,
  parameter int V_FP     = 2,
  parameter int V_SYNC   = 10,
  parameter int V_BP     = 2
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       EN,
  output logic [9:0] H_COUNT,
  output logic [9:0] V_COUNT,
  output logic       Hsync,
  output logic       Vsync,
  output logic       hDE,
  output logic       vDE,
  output logic       DE,
  output logic       line_start,
  output logic       frame_start,
  output logic [7:0] R,
  output logic [7:0] G,
  output logic [7:0] B
);

  // Totals must not exceed 1024 so both counters fit in 10 bits.
  localparam int c_H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int c_V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] c_H_LAST = 10'(c_H_TOTAL - 1);
  localparam logic [9:0] c_V_LAST = 10'(c_V_TOTAL - 1);

  // Window bounds are 11 bits wide so an end bound of exactly 1024 is exact.
  localparam logic [10:0] c_H_ACT      = 11'(H_ACTIVE);
  localparam logic [10:0] c_HS_START   = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] c_HS_END     = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] c_V_ACT      = 11'(V_ACTIVE);
  localparam logic [10:0] c_VS_START   = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] c_VS_END     = 11'(V_ACTIVE + V_FP + V_SYNC);

  localparam logic [0:0] c_ST_IDLE = 1'b0;
  localparam logic [0:0] c_ST_RUN  = 1'b1;

  logic [0:0] r_state;
  logic [0:0] w_state_next;
  logic [9:0] w_h_next;
  logic [9:0] w_v_next;
  logic       w_run;
  logic       w_hde;
  logic       w_vde;
  logic       w_de;
  logic       w_hsync;
  logic       w_vsync;
  logic       w_line_start;
  logic       w_frame_start;
  logic [7:0] w_r;
  logic [7:0] w_g;
  logic [7:0] w_b;

  // Next raster position: EN low parks at idle, first enabled edge starts at 0/0.
  always_comb begin
    w_state_next = r_state;
    w_h_next     = H_COUNT;
    w_v_next     = V_COUNT;
    if (!EN) begin
      w_state_next = c_ST_IDLE;
      w_h_next     = 10'd0;
      w_v_next     = 10'd0;
    end else if (r_state == c_ST_IDLE) begin
      w_state_next = c_ST_RUN;
      w_h_next     = 10'd0;
      w_v_next     = 10'd0;
    end else if (H_COUNT == c_H_LAST) begin
      w_h_next = 10'd0;
      if (V_COUNT == c_V_LAST) begin
        w_v_next = 10'd0;
      end else begin
        w_v_next = V_COUNT + 10'd1;
      end
    end else begin
      w_h_next = H_COUNT + 10'd1;
    end
  end

  // Decode every output from the next position so the registers stay aligned.
  always_comb begin
    w_run         = (w_state_next == c_ST_RUN);
    w_hde         = w_run && ({1'b0, w_h_next} < c_H_ACT);
    w_vde         = w_run && ({1'b0, w_v_next} < c_V_ACT);
    w_de          = w_hde && w_vde;
    w_hsync       = !(w_run && ({1'b0, w_h_next} >= c_HS_START) &&
                      ({1'b0, w_h_next} < c_HS_END));
    w_vsync       = !(w_run && ({1'b0, w_v_next} >= c_VS_START) &&
                      ({1'b0, w_v_next} < c_VS_END));
    w_line_start  = w_run && (w_h_next == 10'd0);
    w_frame_start = w_line_start && (w_v_next == 10'd0);
  end

`ifdef TFT_TIMING_PATTERN_EN
  localparam int c_BAR_W = H_ACTIVE / 8;

  logic [2:0] w_bar;

  // Bar index by threshold compare; the last threshold saturates it at 7.
  always_comb begin
    w_bar = 3'd0;
    for (int k = 1; k < 8; k++) begin
      if ({1'b0, w_h_next} >= 11'(k * c_BAR_W)) begin
        w_bar = 3'(k);
      end
    end
  end

  // Bar order white..black maps to inverted index bits: R=~b1, G=~b2, B=~b0.
  assign w_r = w_de ? {8{~w_bar[1]}} : 8'd0;
  assign w_g = w_de ? {8{~w_bar[2]}} : 8'd0;
  assign w_b = w_de ? {8{~w_bar[0]}} : 8'd0;
`else
  assign w_r = 8'd0;
  assign w_g = 8'd0;
  assign w_b = 8'd0;
`endif

  // Output and state registers; reset forces idle values immediately.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_state     <= c_ST_IDLE;
      H_COUNT     <= 10'd0;
      V_COUNT     <= 10'd0;
      Hsync       <= 1'b1;
      Vsync       <= 1'b1;
      hDE         <= 1'b0;
      vDE         <= 1'b0;
      DE          <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      R           <= 8'd0;
      G           <= 8'd0;
      B           <= 8'd0;
    end else begin
      r_state     <= w_state_next;
      H_COUNT     <= w_h_next;
      V_COUNT     <= w_v_next;
      Hsync       <= w_hsync;
      Vsync       <= w_vsync;
      hDE         <= w_hde;
      vDE         <= w_vde;
      DE          <= w_de;
      line_start  <= w_line_start;
      frame_start <= w_frame_start;
      R           <= w_r;
      G           <= w_g;
      B           <= w_b;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_tft_timing_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_tft_timing_gen
// Description : Self-checking bench for tft_timing_gen. Drives a reduced-size
//               instance (full frames in few cycles) and a default-size
//               instance from the same random EN/RESET stimulus, and compares
//               both every cycle against a linear-pixel-index model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tft_timing_gen;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en  = 1'b0;

  logic [9:0] s_h, s_v, d_h, d_v;
  logic s_hs, s_vs, s_hde, s_vde, s_de, s_ls, s_fs;
  logic d_hs, d_vs, d_hde, d_vde, d_de, d_ls, d_fs;
  logic [7:0] s_r, s_g, s_b, d_r, d_g, d_b;

  tft_timing_gen #(
    .H_ACTIVE(40), .H_FP(3), .H_SYNC(5), .H_BP(4),
    .V_ACTIVE(12), .V_FP(2), .V_SYNC(3), .V_BP(2)
  ) u_small (
    .CLK(clk), .RESET(rst), .EN(en),
    .H_COUNT(s_h), .V_COUNT(s_v), .Hsync(s_hs), .Vsync(s_vs),
    .hDE(s_hde), .vDE(s_vde), .DE(s_de),
    .line_start(s_ls), .frame_start(s_fs),
    .R(s_r), .G(s_g), .B(s_b)
  );

  tft_timing_gen u_dflt (
    .CLK(clk), .RESET(rst), .EN(en),
    .H_COUNT(d_h), .V_COUNT(d_v), .Hsync(d_hs), .Vsync(d_vs),
    .hDE(d_hde), .vDE(d_vde), .DE(d_de),
    .line_start(d_ls), .frame_start(d_fs),
    .R(d_r), .G(d_g), .B(d_b)
  );

  always #5 clk = ~clk;

  logic [50:0] obs0, obs1;
  assign obs0 = {s_h, s_v, s_hs, s_vs, s_hde, s_vde, s_de, s_ls, s_fs, s_r, s_g, s_b};
  assign obs1 = {d_h, d_v, d_hs, d_vs, d_hde, d_vde, d_de, d_ls, d_fs, d_r, d_g, d_b};

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
    n_checks++;
    if (act === want) n_pass++;
    else $display("FAIL %s: got %h, expected %h at t=%0t", name, act, want, $time);
  endtask

  // Instance 0 = reduced timing, instance 1 = default timing.
  int ha [2] = '{40, 480};
  int hfp[2] = '{3, 2};
  int hsw[2] = '{5, 41};
  int hbp[2] = '{4, 2};
  int va [2] = '{12, 272};
  int vfp[2] = '{2, 2};
  int vsw[2] = '{3, 10};
  int vbp[2] = '{2, 2};

  bit m_run[2];
  int m_p  [2];   // linear pixel index within the frame

  function automatic int htot(input int i);
    return ha[i] + hfp[i] + hsw[i] + hbp[i];
  endfunction

  function automatic int vtot(input int i);
    return va[i] + vfp[i] + vsw[i] + vbp[i];
  endfunction

`ifdef TFT_TIMING_PATTERN_EN
  function automatic logic [23:0] bar_colour(input int bar);
    case (bar)
      0: return 24'hFFFFFF;
      1: return 24'hFFFF00;
      2: return 24'h00FFFF;
      3: return 24'h00FF00;
      4: return 24'hFF00FF;
      5: return 24'hFF0000;
      6: return 24'h0000FF;
      default: return 24'h000000;
    endcase
  endfunction
  localparam logic [23:0] EXP_H0   = 24'hFFFFFF;
  localparam logic [23:0] EXP_H59  = 24'hFFFFFF;
  localparam logic [23:0] EXP_H60  = 24'hFFFF00;
  localparam logic [23:0] EXP_H479 = 24'h000000;
`else
  localparam logic [23:0] EXP_H0   = 24'h000000;
  localparam logic [23:0] EXP_H59  = 24'h000000;
  localparam logic [23:0] EXP_H60  = 24'h000000;
  localparam logic [23:0] EXP_H479 = 24'h000000;
`endif

  function automatic logic [50:0] model_out(input int i);
    int h, v;
    logic hde, vde, de, hsn, vsn, ls, fs;
    logic [23:0] rgb;
    if (!m_run[i]) return {20'd0, 2'b11, 5'b00000, 24'd0};
    h   = m_p[i] % htot(i);
    v   = m_p[i] / htot(i);
    hde = (h < ha[i]);
    vde = (v < va[i]);
    de  = hde && vde;
    hsn = !((h >= ha[i] + hfp[i]) && (h < ha[i] + hfp[i] + hsw[i]));
    vsn = !((v >= va[i] + vfp[i]) && (v < va[i] + vfp[i] + vsw[i]));
    ls  = (h == 0);
    fs  = ls && (v == 0);
    rgb = 24'd0;
`ifdef TFT_TIMING_PATTERN_EN
    begin
      int w, bar;
      w   = ha[i] / 8;
      bar = (w == 0) ? 7 : h / w;
      if (bar > 7) bar = 7;
      if (de) rgb = bar_colour(bar);
    end
`endif
    return {h[9:0], v[9:0], hsn, vsn, hde, vde, de, ls, fs, rgb};
  endfunction

  int   cyc = 0;
  int   last_ls_d = -1, last_fs_s = -1;
  int   hde_len = 0, hs_len = 0, vs_len = 0;
  int   mh, mv;
  logic prev_hde = 1'b0, prev_hs = 1'b1, prev_vs = 1'b1;
  logic [9:0] prev_sv = 10'd0;
  bit   was_run[2];

  // Model update on each clock edge or reset assertion, then compare 1 ns later.
  always begin
    @(posedge clk or posedge rst);
    if (clk) cyc++;
    for (int i = 0; i < 2; i++) begin
      was_run[i] = m_run[i];
      if (rst || !en) begin
        m_run[i] = 1'b0;
        m_p[i]   = 0;
      end else if (!m_run[i]) begin
        m_run[i] = 1'b1;
        m_p[i]   = 0;
      end else begin
        m_p[i] = (m_p[i] + 1) % (htot(i) * vtot(i));
      end
    end
    #1;
    chk("small_outputs", obs0, model_out(0));
    chk("dflt_outputs",  obs1, model_out(1));

    if (m_run[0] && !was_run[0]) chk("small_restart", {s_h, s_v, s_fs, s_ls}, {20'd0, 2'b11});
    if (m_run[1] && !was_run[1]) chk("dflt_restart",  {d_h, d_v, d_fs, d_ls}, {20'd0, 2'b11});

    // Default-size line timing and row-0 pattern literals.
    if (m_run[1]) begin
      if (d_ls) begin
        if (last_ls_d >= 0) chk("line_period", cyc - last_ls_d, 525);
        last_ls_d = cyc;
        hde_len   = 0;
      end
      if (d_hde) hde_len++;
      if (prev_hde && !d_hde) chk("hde_width", hde_len, 480);
      if (prev_hs && !d_hs) begin
        chk("hsync_start", d_h, 482);
        hs_len = 0;
      end
      if (!d_hs) hs_len++;
      if (!prev_hs && d_hs) chk("hsync_width", hs_len, 41);
      mh = m_p[1] % 525;
      mv = m_p[1] / 525;
      if (mv == 0) begin
        case (mh)
          0:   chk("rgb_h0",   {d_r, d_g, d_b}, EXP_H0);
          59:  chk("rgb_h59",  {d_r, d_g, d_b}, EXP_H59);
          60:  chk("rgb_h60",  {d_r, d_g, d_b}, EXP_H60);
          479: chk("rgb_h479", {d_r, d_g, d_b}, EXP_H479);
          480: chk("rgb_h480", {d_r, d_g, d_b, d_de}, 25'd0);
          default: ;
        endcase
      end
      prev_hde = d_hde;
      prev_hs  = d_hs;
    end else begin
      last_ls_d = -1;
      prev_hde  = 1'b0;
      prev_hs   = 1'b1;
    end

    // Reduced-size frame timing (52 x 19 = 988 cycles per frame).
    if (m_run[0]) begin
      if (s_fs) begin
        if (last_fs_s >= 0) begin
          chk("frame_period", cyc - last_fs_s, 988);
          chk("v_wrap_from", prev_sv, 18);
        end
        last_fs_s = cyc;
      end
      if (prev_vs && !s_vs) begin
        chk("vsync_start", {s_v, s_h}, {10'd14, 10'd0});
        vs_len = 0;
      end
      if (!s_vs) vs_len++;
      if (!prev_vs && s_vs) chk("vsync_width", vs_len, 156);
      prev_vs = s_vs;
      prev_sv = s_v;
    end else begin
      last_fs_s = -1;
      prev_vs   = 1'b1;
    end
  end

  // Stimulus: reset, idle, long run, EN drops, async reset pulses, EN chatter.
  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    en = 1'b1;
    repeat (3000) @(negedge clk);
    for (int n = 0; n < 6; n++) begin
      repeat ($urandom_range(200, 1500)) @(negedge clk);
      en = 1'b0;
      repeat ($urandom_range(1, 4)) @(negedge clk);
      en = 1'b1;
    end
    for (int n = 0; n < 4; n++) begin
      repeat ($urandom_range(300, 1200)) @(negedge clk);
      #2 rst = 1'b1;
      #1 rst = 1'b0;
    end
    for (int n = 0; n < 600; n++) begin
      @(negedge clk);
      en = ($urandom_range(0, 7) != 0);
    end
    en = 1'b1;
    repeat (1200) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/tft_timing_gen.md
# tft_timing_gen

TFT-LCD raster timing generator on the pixel clock (TCLK domain). It produces the horizontal/vertical sync, data-enable and pixel/line counters that the LCD control stage consumes on its Hsync/Vsync inputs, and that the BRAM controller and tracker use for addressing. With the pattern feature compiled in, it also drives an 8-bar colour test pattern aligned with DE.

## Interface
- H_ACTIVE, 480, visible pixels per line
- H_FP, 2, horizontal front porch (cycles)
- H_SYNC, 41, Hsync low width (cycles)
- H_BP, 2, horizontal back porch (cycles)
- V_ACTIVE, 272, visible lines per frame
- V_FP, 2, vertical front porch (lines)
- V_SYNC, 10, Vsync low width (lines)
- V_BP, 2, vertical back porch (lines)
- CLK  input  1  pixel clock; all logic on its rising edge
- RESET  input  1  asynchronous, active-high reset
- EN  input  1  run enable; low forces the idle state
- H_COUNT  output  10  pixel index within line, 0..H_TOTAL-1
- V_COUNT  output  10  line index within frame, 0..V_TOTAL-1
- Hsync  output  1  horizontal sync, active low
- Vsync  output  1  vertical sync, active low
- hDE  output  1  high while H_COUNT < H_ACTIVE
- vDE  output  1  high while V_COUNT < V_ACTIVE
- DE  output  1  hDE & vDE
- line_start  output  1  one-cycle pulse when H_COUNT==0
- frame_start  output  1  one-cycle pulse when H_COUNT==0 and V_COUNT==0
- R, G, B  output  8 each  test-pattern pixel (see Configuration)

## Operation
- Totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (default 525). V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (default 286). Both totals must be ≤ 1024. Counters are unsigned 10-bit.
- Line order: active, then FP, then SYNC, then BP. The frame uses the same order, in lines.
- Internal `running` flag. Two states:
  - IDLE: running=0.
  - RUN: running=1.
- IDLE behaviour:
  - H_COUNT=V_COUNT=0.
  - Hsync=Vsync=1.
  - hDE=vDE=DE=0.
  - line_start=frame_start=0.
  - R=G=B=0.
- IDLE→RUN on the first edge with EN=1. That edge presents H=0, V=0, hDE=vDE=DE=1 and line_start=frame_start=1.
- RUN, per edge with EN=1:
  - H_COUNT increments.
  - At H_TOTAL-1, H_COUNT wraps to 0 and V_COUNT increments.
  - At V_TOTAL-1 with H wrapping, V_COUNT wraps to 0.
- RUN→IDLE on any edge with EN=0. Idle values appear on that edge. No partial-line completion.
- Hsync=0 exactly when H_ACTIVE+H_FP ≤ H_COUNT < H_ACTIVE+H_FP+H_SYNC (default 482..522).
- Vsync=0 exactly when V_ACTIVE+V_FP ≤ V_COUNT < V_ACTIVE+V_FP+V_SYNC (default 274..283). Vsync edges therefore coincide with H_COUNT==0.
- RESET asserted at any time, including mid-frame, forces IDLE immediately (asynchronously). Restart follows the IDLE→RUN rule.

## Timing
- All outputs are registered; there is no combinational input→output path.
- All outputs are mutually aligned. In the cycle H_COUNT/V_COUNT show value n, every other output reflects n. Zero skew between counters, syncs, DE and RGB.
- EN→output latency: 1 edge.
- Line period: H_TOTAL cycles. Frame period: H_TOTAL*V_TOTAL cycles (default 150150).
- Reset values of all outputs: counters 0, Hsync=Vsync=1, DE/hDE/vDE/pulses 0, RGB 0.

## Configuration
- Macro: TFT_TIMING_PATTERN_EN.
- Defined:
  - Bar width W = H_ACTIVE/8 (default 60). Bar index = H_COUNT/W, saturated at 7.
  - Bars, in index order: white FFFFFF, yellow FFFF00, cyan 00FFFF, green 00FF00, magenta FF00FF, red FF0000, blue 0000FF, black 000000.
  - R/G/B equal the bar colour when DE=1, otherwise 0.
- Not defined: R/G/B are tied to 0 and no pattern logic is synthesized. All timing outputs are identical in both builds.

## Test plan
- Reset/idle: RESET=1, then release with EN=0 for 10 cycles -> Hsync=Vsync=1, DE=0, H_COUNT=V_COUNT=0, RGB=0 throughout.
- Line timing: EN=1 from idle -> frame_start on the first edge. hDE high for 480 cycles. Hsync low for 41 cycles starting at H_COUNT=482. The next line_start comes 525 cycles after the previous one.
- Frame timing: run 2 frames -> vDE high for V_COUNT 0..271. Vsync low for 10 lines starting at V_COUNT=274, H_COUNT=0. frame_start pulses are 150150 cycles apart. V_COUNT wraps 285→0.
- EN drop mid-frame: deassert EN at V=100, H=200 -> next edge is idle values. Reassert EN -> next edge shows H=0, V=0, frame_start=1.
- Async reset mid-frame: pulse RESET between edges at V=150 -> outputs show reset values before the next edge. Restart is as in the EN test.
- Pattern (macro defined): row 0 -> RGB=FFFFFF at H=0 and at H=59, FFFF00 at H=60, 000000 at H=479, 0 at H=480 (DE=0). With the macro undefined, RGB=0 at all H.
